nec_key_event: RTL and testbench

Key-event generator sitting directly downstream of the NEC IR decoder. Converts the decoder's level-style outputs (address, data, dataready, repeat_code) into discrete PRESS / HOLD / RELEASE events. Events are queued in a 4-entry FIFO and handed to a host-side consumer (UART reporter, CPU register bank) over a valid/ready handshake.

---
 rtl/nec_key_event_if.sv | 27 ++
 rtl/nec_key_event.sv | 211 +++++++++++++++++++++
 tb/tb_nec_key_event.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/nec_key_event_if.sv
// nec_key_event_if: event handshake between the key-event generator and
// its host-side consumer.
//   evt_valid   - head-of-queue event present (producer -> consumer)
//   evt_ready   - consumer accepts the head this cycle (consumer -> producer)
//   evt_type    - 01 PRESS, 10 HOLD, 11 RELEASE
//   evt_address - NEC address of the event's key
//   evt_data    - NEC command of the event's key
//   evt_drop    - one-cycle pulse: an event was discarded (queue full)
// Modports: master = event producer, slave = event consumer.
interface nec_key_event_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_type;
  logic [7:0] evt_address;
  logic [7:0] evt_data;
  logic       evt_drop;

  modport master (
    output evt_valid, evt_type, evt_address, evt_data, evt_drop,
    input  evt_ready
  );

  modport slave (
    input  evt_valid, evt_type, evt_address, evt_data, evt_drop,
    output evt_ready
  );
endinterface

// File: rtl/nec_key_event.sv
// nec_key_event: turns the NEC decoder's level outputs into discrete
// PRESS / HOLD / RELEASE events, queued in a 4-deep FIFO.
// Ports:
//   clk, rst       - system clock, asynchronous active-high reset
//   in_address     - decoder address
//   in_data        - decoder command
//   in_dataready   - decoder valid-frame level
//   in_repeat      - decoder repeat level
//   evt            - event handshake (nec_key_event_if.master)
// Parameters:
//   RELEASE_TICKS  - idle clk cycles before a held key is released
//   HOLD_DIV       - accepted repeats per HOLD event (0 behaves as 1)
//   FILTER_ADDR    - only address accepted for new frames when the
//                    NEC_ADDR_FILTER_EN macro is defined; unused otherwise
module nec_key_event #(
  parameter logic [23:0] RELEASE_TICKS = 24'd12000000,
  parameter logic [3:0]  HOLD_DIV      = 4'd3,
  parameter logic [7:0]  FILTER_ADDR   = 8'h00
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_address,
  input  logic [7:0]             in_data,
  input  logic                   in_dataready,
  input  logic                   in_repeat,
  nec_key_event_if.master        evt
);

  typedef enum logic [1:0] {
    EVT_NONE    = 2'b00,
    EVT_PRESS   = 2'b01,
    EVT_HOLD    = 2'b10,
    EVT_RELEASE = 2'b11
  } evt_type_e;

  typedef enum logic {ST_IDLE, ST_HELD} key_state_e;

  localparam logic [3:0]  HOLD_DIV_EFF = (HOLD_DIV == 4'd0) ? 4'd1 : HOLD_DIV;
  localparam logic [23:0] RELEASE_LAST = RELEASE_TICKS - 24'd1;

  // Registered copies of the decoder outputs, used for edge/change detection.
  logic [7:0]  r_address_q, r_data_q;
  logic        r_dataready_q, r_repeat_q;

  key_state_e  state_q, state_d;
  logic [7:0]  k_addr_q, k_addr_d, k_data_q, k_data_d;
  logic        pending_q, pending_d;
  logic [3:0]  div_q, div_d;
  logic [23:0] cnt_q, cnt_d;

  logic [17:0] mem [0:3];
  logic [1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  logic        valid_q, valid_d;
  logic [17:0] head_q, head_d;
  logic        drop_q, drop_d;

  logic        addr_ok, frame_new, rep_edge, same_key, held;
  logic        push, do_write, pop, full;
  evt_type_e   push_type;
  logic [7:0]  push_addr, push_data;
  logic [17:0] push_entry;
  logic [3:0]  div_inc;

`ifdef NEC_ADDR_FILTER_EN
  assign addr_ok = (in_address == FILTER_ADDR);
`else
  logic unused_filter_addr;
  assign unused_filter_addr = ^FILTER_ADDR;
  assign addr_ok = 1'b1;
`endif

  // A frame is new on a dataready rising edge, or when the key changes while
  // dataready stays high (decoder replaced the frame without dropping ready).
  assign frame_new = addr_ok && in_dataready &&
                     (!r_dataready_q || ({in_address, in_data} != {r_address_q, r_data_q}));
  assign rep_edge  = in_repeat && !r_repeat_q;
  assign held      = (state_q == ST_HELD);
  assign same_key  = ({in_address, in_data} == {k_addr_q, k_data_q});
  assign div_inc   = div_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    k_addr_d  = k_addr_q;
    k_data_d  = k_data_q;
    pending_d = pending_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    push_type = EVT_NONE;
    push_addr = k_addr_q;
    push_data = k_data_q;

    if (pending_q) begin
      // Deferred PRESS of a key change; anything detected now is lost,
      // but a repeat still counts as activity for the release timer.
      push      = 1'b1;
      push_type = EVT_PRESS;
      pending_d = 1'b0;
      cnt_d     = rep_edge ? 24'd0 : cnt_q + 24'd1;
    end else if (frame_new && (!held || !same_key)) begin
      push = 1'b1;
      if (!held) begin
        push_type = EVT_PRESS;
        push_addr = in_address;
        push_data = in_data;
        state_d   = ST_HELD;
      end else begin
        push_type = EVT_RELEASE;
        pending_d = 1'b1;
      end
      k_addr_d = in_address;
      k_data_d = in_data;
      div_d    = 4'd0;
      cnt_d    = 24'd0;
    end else if (held && (frame_new || rep_edge)) begin
      // Repeat, or re-sent frame of the key already held.
      cnt_d = 24'd0;
      if (div_inc >= HOLD_DIV_EFF) begin
        push      = 1'b1;
        push_type = EVT_HOLD;
        div_d     = 4'd0;
      end else begin
        div_d = div_inc;
      end
    end else if (held) begin
      if (cnt_q >= RELEASE_LAST) begin
        push      = 1'b1;
        push_type = EVT_RELEASE;
        state_d   = ST_IDLE;
        cnt_d     = 24'd0;
        div_d     = 4'd0;
      end else begin
        cnt_d = cnt_q + 24'd1;
      end
    end
  end

  assign push_entry = {push_type, push_addr, push_data};
  assign full       = (count_q == 3'd4);
  assign pop        = valid_q && evt.evt_ready;
  assign do_write   = push && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + {1'b0, do_write};
    rd_ptr_d = rd_ptr_q + {1'b0, pop};
    count_d  = count_q + {2'b00, do_write} - {2'b00, pop};
    drop_d   = push && full && !pop;
    valid_d  = (count_d != 3'd0);
    // The head register is loaded with the entry that will sit at the read
    // pointer; if that slot is being written this cycle, take the new entry.
    if (count_d == 3'd0) begin
      head_d = '0;
    end else if (do_write && (wr_ptr_q == rd_ptr_d)) begin
      head_d = push_entry;
    end else begin
      head_d = mem[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr_q] <= push_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_address_q   <= 8'h00;
      r_data_q      <= 8'h00;
      r_dataready_q <= 1'b0;
      r_repeat_q    <= 1'b0;
      state_q       <= ST_IDLE;
      k_addr_q      <= 8'h00;
      k_data_q      <= 8'h00;
      pending_q     <= 1'b0;
      div_q         <= 4'd0;
      cnt_q         <= 24'd0;
      wr_ptr_q      <= 2'd0;
      rd_ptr_q      <= 2'd0;
      count_q       <= 3'd0;
      valid_q       <= 1'b0;
      head_q        <= '0;
      drop_q        <= 1'b0;
    end else begin
      r_address_q   <= in_address;
      r_data_q      <= in_data;
      r_dataready_q <= in_dataready;
      r_repeat_q    <= in_repeat;
      state_q       <= state_d;
      k_addr_q      <= k_addr_d;
      k_data_q      <= k_data_d;
      pending_q     <= pending_d;
      div_q         <= div_d;
      cnt_q         <= cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      valid_q       <= valid_d;
      head_q        <= head_d;
      drop_q        <= drop_d;
    end
  end

  assign evt.evt_valid   = valid_q;
  assign evt.evt_type    = head_q[17:16];
  assign evt.evt_address = head_q[15:8];
  assign evt.evt_data    = head_q[7:0];
  assign evt.evt_drop    = drop_q;

endmodule

// File: tb/tb_nec_key_event.sv
// Directed bench for nec_key_event with RELEASE_TICKS=100, HOLD_DIV=3.
module tb_nec_key_event;
  localparam logic [23:0] T_REL = 24'd100;
`ifdef NEC_ADDR_FILTER_EN
  localparam logic [7:0] KEY_ADDR = 8'h10;
`else
  localparam logic [7:0] KEY_ADDR = 8'h00;
`endif
  localparam logic [1:0] T_PRESS = 2'b01;
  localparam logic [1:0] T_HOLD  = 2'b10;
  localparam logic [1:0] T_REL_E = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_address = 8'h00;
  logic [7:0] in_data = 8'h00;
  logic       in_dataready = 1'b0;
  logic       in_repeat = 1'b0;
  int         n_asserts = 0;
  int         n_fails = 0;

  nec_key_event_if evt_if ();

  nec_key_event #(
    .RELEASE_TICKS(T_REL),
    .HOLD_DIV(4'd3),
    .FILTER_ADDR(KEY_ADDR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_address(in_address),
    .in_data(in_data),
    .in_dataready(in_dataready),
    .in_repeat(in_repeat),
    .evt(evt_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [1:0] typ,
                          input logic [7:0] addr, input logic [7:0] data);
    chk({tag, ".valid"}, {31'd0, evt_if.evt_valid}, 32'd1);
    chk({tag, ".type"},  {30'd0, evt_if.evt_type}, {30'd0, typ});
    chk({tag, ".addr"},  {24'd0, evt_if.evt_address}, {24'd0, addr});
    chk({tag, ".data"},  {24'd0, evt_if.evt_data}, {24'd0, data});
  endtask

  // Check the head, then pop it with a one-cycle ready.
  task automatic pop_evt(input string tag, input logic [1:0] typ,
                         input logic [7:0] addr, input logic [7:0] data);
    chk_head(tag, typ, addr, data);
    $display("[%0t] %s: type=%b addr=%02h data=%02h", $time, tag,
             evt_if.evt_type, evt_if.evt_address, evt_if.evt_data);
    evt_if.evt_ready = 1'b1;
    tick();
    evt_if.evt_ready = 1'b0;
  endtask

  task automatic frame(input logic [7:0] addr, input logic [7:0] data);
    in_address   = addr;
    in_data      = data;
    in_dataready = 1'b1;
    tick();
  endtask

  task automatic rep_pulse();
    in_repeat = 1'b1;
    tick();
    in_repeat = 1'b0;
    tick();
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int i = 0;
    while (!evt_if.evt_valid && i < budget) begin
      tick();
      i++;
    end
    chk(tag, {31'd0, evt_if.evt_valid}, 32'd1);
  endtask

  initial begin
    evt_if.evt_ready = 1'b0;
    tick();
    tick();
    // Reset state
    chk("rst.valid", {31'd0, evt_if.evt_valid}, 32'd0);
    chk("rst.type",  {30'd0, evt_if.evt_type}, 32'd0);
    chk("rst.addr",  {24'd0, evt_if.evt_address}, 32'd0);
    chk("rst.data",  {24'd0, evt_if.evt_data}, 32'd0);
    chk("rst.drop",  {31'd0, evt_if.evt_drop}, 32'd0);
    rst = 1'b0;
    tick();

`ifdef NEC_ADDR_FILTER_EN
    // Frame from a foreign address is ignored entirely.
    frame(8'h20, 8'h45);
    chk("filt.no_evt", {31'd0, evt_if.evt_valid}, 32'd0);
    in_dataready = 1'b0;
    tick();
    chk("filt.still_none", {31'd0, evt_if.evt_valid}, 32'd0);
`endif

    // Press / release: RELEASE pushed 100 edges after the PRESS push.
    frame(KEY_ADDR, 8'h45);
    in_dataready = 1'b0;
    pop_evt("pr.press", T_PRESS, KEY_ADDR, 8'h45);
    repeat (98) tick();
    chk("pr.not_early", {31'd0, evt_if.evt_valid}, 32'd0);
    tick();
    pop_evt("pr.release", T_REL_E, KEY_ADDR, 8'h45);
    chk("pr.empty", {31'd0, evt_if.evt_valid}, 32'd0);

    // Hold: 7 repeats with divider 3 -> exactly two HOLDs.
    frame(KEY_ADDR, 8'h45);
    in_dataready = 1'b0;
    pop_evt("hold.press", T_PRESS, KEY_ADDR, 8'h45);
    for (int i = 0; i < 7; i++) rep_pulse();
    pop_evt("hold.h1", T_HOLD, KEY_ADDR, 8'h45);
    pop_evt("hold.h2", T_HOLD, KEY_ADDR, 8'h45);
    chk("hold.no_third", {31'd0, evt_if.evt_valid}, 32'd0);
    repeat (96) tick();
    chk("hold.not_early", {31'd0, evt_if.evt_valid}, 32'd0);
    tick();
    pop_evt("hold.release", T_REL_E, KEY_ADDR, 8'h45);

    // Key change with dataready held high.
    frame(KEY_ADDR, 8'h45);
    pop_evt("kc.press45", T_PRESS, KEY_ADDR, 8'h45);
    in_data = 8'h46;
    tick();
    chk_head("kc.rel45", T_REL_E, KEY_ADDR, 8'h45);
    evt_if.evt_ready = 1'b1;
    tick();
    evt_if.evt_ready = 1'b0;
    chk_head("kc.press46_next", T_PRESS, KEY_ADDR, 8'h46);
    pop_evt("kc.press46", T_PRESS, KEY_ADDR, 8'h46);
    chk("kc.empty", {31'd0, evt_if.evt_valid}, 32'd0);
    in_dataready = 1'b0;
    wait_valid("kc.wait_rel", 200);
    pop_evt("kc.rel46", T_REL_E, KEY_ADDR, 8'h46);

    // Overflow: four events fill the FIFO, the fifth (HOLD 46) is dropped.
    frame(KEY_ADDR, 8'h45);
    in_dataready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) rep_pulse();
    frame(KEY_ADDR, 8'h46);
    in_dataready = 1'b0;
    tick();
    chk("ovf.no_drop_yet", {31'd0, evt_if.evt_drop}, 32'd0);
    chk_head("ovf.head", T_PRESS, KEY_ADDR, 8'h45);
    rep_pulse();
    rep_pulse();
    in_repeat = 1'b1;
    tick();
    chk("ovf.drop", {31'd0, evt_if.evt_drop}, 32'd1);
    in_repeat = 1'b0;
    tick();
    chk("ovf.drop_one_cycle", {31'd0, evt_if.evt_drop}, 32'd0);
    chk_head("ovf.head_kept", T_PRESS, KEY_ADDR, 8'h45);

    // Full FIFO with a push and a pop in the same cycle: no drop.
    rep_pulse();
    rep_pulse();
    in_repeat = 1'b1;
    evt_if.evt_ready = 1'b1;
    tick();
    in_repeat = 1'b0;
    evt_if.evt_ready = 1'b0;
    chk("fpp.no_drop", {31'd0, evt_if.evt_drop}, 32'd0);
    pop_evt("fpp.hold45", T_HOLD, KEY_ADDR, 8'h45);
    pop_evt("fpp.rel45", T_REL_E, KEY_ADDR, 8'h45);
    pop_evt("fpp.press46", T_PRESS, KEY_ADDR, 8'h46);
    pop_evt("fpp.hold46", T_HOLD, KEY_ADDR, 8'h46);
    chk("fpp.empty", {31'd0, evt_if.evt_valid}, 32'd0);
    wait_valid("fpp.wait_rel", 200);
    pop_evt("fpp.rel46", T_REL_E, KEY_ADDR, 8'h46);

    // Asynchronous reset mid-hold: queue cleared at once, no RELEASE later.
    frame(KEY_ADDR, 8'h45);
    in_dataready = 1'b0;
    chk_head("arst.press", T_PRESS, KEY_ADDR, 8'h45);
    repeat (10) tick();
    rst = 1'b1;
    #1;
    chk("arst.valid", {31'd0, evt_if.evt_valid}, 32'd0);
    chk("arst.type", {30'd0, evt_if.evt_type}, 32'd0);
    chk("arst.data", {24'd0, evt_if.evt_data}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    rep_pulse();
    chk("arst.rep_ignored", {31'd0, evt_if.evt_valid}, 32'd0);
    repeat (120) tick();
    chk("arst.no_release", {31'd0, evt_if.evt_valid}, 32'd0);
    frame(KEY_ADDR, 8'h47);
    in_dataready = 1'b0;
    pop_evt("arst.press47", T_PRESS, KEY_ADDR, 8'h47);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end
endmodule
